// File: rtl/cache_ctrl.sv
// -----------------------------------------------------------------------------
// cache_ctrl
//   Direct-mapped, one-word-per-line cache controller. Write-through with
//   write-allocate. The controller owns the valid bits and the tag store; the
//   external data array only holds data words.
//
// Handshake semantics (one place for all of them):
//   - CPU side:  cpu_req/cpu_we/cpu_addr/cpu_wdata are sampled only while the
//     FSM is idle. Exactly one cpu_ready pulse (one cycle) ends each accepted
//     access. cpu_rdata is valid during that pulse and holds until the next
//     read capture. Requests seen outside idle are dropped, never queued.
//   - Memory side: mem_req (with mem_we, mem_addr, mem_wdata) is held high
//     until a one-cycle mem_ack. mem_rdata is valid together with mem_ack.
//     mem_ack arriving while no request is outstanding is ignored.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cpu_req/cpu_we/cpu_addr/
//   cpu_wdata                     CPU request
//   cpu_rdata/cpu_ready           CPU response
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_rdata/mem_ack   main-memory port
//   c_mwr/c_moe/c_adr/c_mwd/c_crd cache data-array port (array writes on the
//                                 falling edge while c_mwr=1; c_crd is
//                                 combinational from c_adr)
//   dbg_state                     current FSM state, for observation only
// -----------------------------------------------------------------------------
module cache_ctrl #(
  parameter int LINES = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        c_mwr,
  output logic        c_moe,
  output logic [31:0] c_adr,
  output logic [31:0] c_mwd,
  input  logic [31:0] c_crd,
  output logic [2:0]  dbg_state
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_MEM_RD = 3'd2,
    S_MEM_WR = 3'd3,
    S_FILL   = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  state_t state_q, state_d;

  // Latched request; these also drive the address/data outputs directly so
  // they stay stable from LOOKUP through RESP.
  logic [31:0] addr_q,  addr_d;
  logic        we_q,    we_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mwd_q,   mwd_d;

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [LINES];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic             tag_we;

  assign idx = addr_q[IDX_W-1:0];
  assign tag = addr_q[31:IDX_W];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        // Every write goes to memory (write-through) and then allocates.
        if (we_q)     state_d = S_MEM_WR;
        else if (hit) state_d = S_RESP;
        else          state_d = S_MEM_RD;
      end
      S_MEM_RD: begin
        if (mem_ack) state_d = S_FILL;
      end
      S_MEM_WR: begin
        if (mem_ack) state_d = S_FILL;
      end
      S_FILL:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (pure decode of the current state)
  // ---------------------------------------------------------------------------
  always_comb begin
    cpu_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    c_mwr     = 1'b0;
    c_moe     = 1'b0;
    tag_we    = 1'b0;
    case (state_q)
      S_LOOKUP: c_moe = 1'b1;
      S_MEM_RD: mem_req = 1'b1;
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      S_FILL: begin
        c_mwr  = 1'b1;
        tag_we = 1'b1;
      end
      S_RESP:  cpu_ready = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mwd_d   = mwd_q;
    valid_d = valid_q;

    if (state_q == S_IDLE && cpu_req) begin
      addr_d  = cpu_addr;
      we_d    = cpu_we;
      wdata_d = cpu_wdata;
    end

    // Read hit: the data array answers combinationally during LOOKUP.
    if (state_q == S_LOOKUP && !we_q && hit) begin
      rdata_d = c_crd;
    end

    if (state_q == S_MEM_RD && mem_ack) begin
      rdata_d = mem_rdata;
      mwd_d   = mem_rdata;
    end

    // cpu_rdata is left alone on writes: it only changes on a read capture.
    if (state_q == S_MEM_WR && mem_ack) begin
      mwd_d = wdata_q;
    end

    // Allocation overwrites whatever line was there; no write-back needed
    // because memory is always up to date.
    if (state_q == S_FILL) begin
      valid_d[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      mwd_q   <= '0;
      valid_q <= '0;
    end else begin
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mwd_q   <= mwd_d;
      valid_q <= valid_d;
    end
  end

  // Tag store has no reset: a tag is only meaningful once its valid bit is
  // set, and valid bits are cleared by reset.
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_q[idx] <= tag;
    end
  end

  assign cpu_rdata = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign c_adr     = addr_q;
  assign c_mwd     = mwd_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_ctrl
//   Randomized and directed stimulus for cache_ctrl. The reference model is a
//   flat word memory plus a per-index valid/tag record: because the cache is
//   write-through and write-allocate, every read returns the memory word for
//   that address; the valid/tag record only decides whether an access is a
//   hit (no memory traffic, two-cycle latency) or goes to memory.
//   The bench also emulates the main memory and the cache data array.
// -----------------------------------------------------------------------------
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        c_mwr;
  logic        c_moe;
  logic [31:0] c_adr;
  logic [31:0] c_mwd;
  logic [31:0] c_crd;
  logic [2:0]  dbg_state;

  // ---------------------------------------------------------------------------
  // Clock / reset infrastructure
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cache_ctrl #(.LINES(128)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .c_mwr     (c_mwr),
    .c_moe     (c_moe),
    .c_adr     (c_adr),
    .c_mwd     (c_mwd),
    .c_crd     (c_crd),
    .dbg_state (dbg_state)
  );

  // Cache data-array emulation: falling-edge write, combinational read.
  logic [31:0] arr [128];
  initial for (int i = 0; i < 128; i++) arr[i] = 32'h0;
  always @(negedge clk) if (c_mwr) arr[c_adr[6:0]] = c_mwd;
  assign c_crd = arr[c_adr[6:0]];

  logic        resp_ack  = 1'b0;
  logic        stray_ack = 1'b0;
  logic [31:0] resp_rdata = 32'h0;
  assign mem_ack   = resp_ack | stray_ack;
  assign mem_rdata = resp_rdata;

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        we;
    logic        hit;
    logic [31:0] rdata;
    int          issue_cyc;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mexp_t;

  exp_t  exp_q[$];
  mexp_t mem_exp_q[$];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [31:0] mem_m [logic [31:0]];
  bit          vld_m [128];
  logic [24:0] tag_m [128];
  logic [31:0] last_rdata;
  int          force_delay = 0;
  bit          mem_hold = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) vld_m[i] = 1'b0;
    last_rdata = 32'h0;
  endtask

  task automatic model_push(input logic we, input logic [31:0] a,
                            input logic [31:0] wd, input bit push_exp);
    exp_t        e;
    mexp_t       m;
    logic [6:0]  ix;
    logic [24:0] tg;
    ix = a[6:0];
    tg = a[31:7];
    e.we        = we;
    e.hit       = vld_m[ix] && (tag_m[ix] == tg);
    e.issue_cyc = cyc;
    if (we) begin
      mem_m[a] = wd;
      e.rdata  = last_rdata;
    end else begin
      e.rdata    = mem_word(a);
      last_rdata = e.rdata;
    end
    if (we || !e.hit) begin
      m.we = we; m.addr = a; m.wdata = wd;
      mem_exp_q.push_back(m);
    end
    vld_m[ix] = 1'b1;
    tag_m[ix] = tg;
    if (push_exp) exp_q.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic issue_start(input logic we, input logic [31:0] a,
                             input logic [31:0] wd, input bit push_exp);
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
    model_push(we, a, wd, push_exp);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cpu_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) check("ready_timeout", 32'(cpu_ready), 32'd1);
  endtask

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd);
    issue_start(we, a, wd, 1'b1);
    @(negedge clk);
    cpu_req  = 1'b0;
    cpu_addr = $urandom;
    wait_ready();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Main-memory responder
  // ---------------------------------------------------------------------------
  initial begin : responder
    mexp_t m;
    int    d, req_cnt, we_cnt, addr_bad, g;
    bit    known;
    forever begin
      @(negedge clk);
      if (mem_req && !rst) begin
        known = (mem_exp_q.size() != 0);
        if (!known) begin
          check("unexpected_mem_req", 32'(mem_req), 32'd0);
          m.we = 1'b0; m.addr = 32'h0; m.wdata = 32'h0;
        end else begin
          m = mem_exp_q.pop_front();
          check("mem_addr", mem_addr, m.addr);
          check("mem_we", 32'(mem_we), 32'(m.we));
          if (m.we) check("mem_wdata", mem_wdata, m.wdata);
        end
        if (mem_hold) begin
          g = 0;
          while (mem_req && g < 50) begin
            @(negedge clk);
            g++;
          end
          check("held_req_dropped", 32'(mem_req), 32'd0);
        end else begin
          d = (force_delay > 0) ? force_delay : int'($urandom_range(1, 4));
          req_cnt = 0; we_cnt = 0; addr_bad = 0;
          for (int k = 0; k < d; k++) begin
            if (k > 0) @(negedge clk);
            if (mem_req) req_cnt++;
            if (mem_we)  we_cnt++;
            if (known && mem_addr !== m.addr) addr_bad++;
          end
          check("mem_req_held", 32'(req_cnt), 32'(d));
          if (known) check("mem_we_cycles", 32'(we_cnt), m.we ? 32'(d) : 32'd0);
          check("mem_addr_stable", 32'(addr_bad), 32'd0);
          resp_ack   = 1'b1;
          resp_rdata = m.we ? $urandom : mem_word(m.addr);
          @(negedge clk);
          resp_ack   = 1'b0;
          resp_rdata = $urandom;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response monitor
  // ---------------------------------------------------------------------------
  initial begin : monitor
    exp_t e;
    int   fill_cnt = 0;
    int   moe_cnt  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        fill_cnt = 0;
        moe_cnt  = 0;
      end else begin
        if (c_mwr) fill_cnt++;
        if (c_moe) moe_cnt++;
        if (cpu_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_ready", 32'(cpu_ready), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("cpu_rdata", cpu_rdata, e.rdata);
            check("fill_pulses", 32'(fill_cnt), (e.we || !e.hit) ? 32'd1 : 32'd0);
            check("lookup_moe", 32'(moe_cnt), 32'd1);
            if (!e.we && e.hit) check("hit_latency", 32'(cyc - e.issue_cyc), 32'd2);
          end
          fill_cnt = 0;
          moe_cnt  = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stim
    int          n;
    int          mwr_seen, rdy_seen;
    logic [31:0] a;
    logic [6:0]  ix;
    logic [24:0] tg;

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_mem_req",   32'(mem_req), 32'd0);
    check("rst_mem_we",    32'(mem_we), 32'd0);
    check("rst_c_mwr",     32'(c_mwr), 32'd0);
    check("rst_c_moe",     32'(c_moe), 32'd0);
    check("rst_mem_addr",  mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_c_adr",     c_adr, 32'h0);
    check("rst_c_mwd",     c_mwd, 32'h0);
    check("rst_state",     32'(dbg_state), 32'd0);
    rst = 1'b0;

    // Directed sequence around a shared index and the top index/tag.
    mem_m[32'h5] = 32'hDEADBEEF;
    issue(1'b0, 32'h0000_0005, 32'h0);
    issue(1'b0, 32'h0000_0005, 32'h0);
    issue(1'b0, 32'h0000_0085, 32'h0);
    issue(1'b0, 32'h0000_0005, 32'h0);
    force_delay = 5;
    issue(1'b1, 32'h0000_007F, 32'h1234_5678);
    force_delay = 0;
    issue(1'b0, 32'h0000_007F, 32'h0);
    issue(1'b1, 32'hFFFF_FFFF, 32'hCAFE_F00D);
    issue(1'b0, 32'hFFFF_FFFF, 32'h0);
    issue(1'b1, 32'h0000_0085, 32'hA5A5_5A5A);
    issue(1'b0, 32'h0000_0085, 32'h0);

    // Stray mem_ack while idle must not disturb anything.
    @(negedge clk);
    stray_ack  = 1'b1;
    resp_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    stray_ack = 1'b0;
    check("stray_ready",  32'(cpu_ready), 32'd0);
    check("stray_memreq", 32'(mem_req), 32'd0);
    check("stray_mwr",    32'(c_mwr), 32'd0);
    check("stray_rdata",  cpu_rdata, last_rdata);
    check("stray_state",  32'(dbg_state), 32'd0);

    // cpu_req held across a miss: one access per cpu_ready, no queuing.
    issue_start(1'b0, 32'h0000_03C0, 32'h0, 1'b1);
    wait_ready();
    @(negedge clk);
    model_push(1'b0, 32'h0000_03C0, 32'h0, 1'b1);
    @(negedge clk);
    wait_ready();
    cpu_req = 1'b0;
    repeat (4) @(negedge clk);
    check("held_req_idle", 32'(dbg_state), 32'd0);

    // Reset while a read miss is waiting on memory, followed by late acks.
    mem_hold = 1'b1;
    issue_start(1'b0, 32'h0000_0200, 32'h0, 1'b0);
    @(negedge clk);
    cpu_req = 1'b0;
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_test_mem_req_seen", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_drop_mem_req", 32'(mem_req), 32'd0);
    check("rst_to_idle",      32'(dbg_state), 32'd0);
    mwr_seen = 0; rdy_seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (k == 1) stray_ack = 1'b0;
      if (c_mwr) mwr_seen++;
      if (cpu_ready) rdy_seen++;
      @(negedge clk);
    end
    check("rst_no_fill",  32'(mwr_seen), 32'd0);
    check("rst_no_ready", 32'(rdy_seen), 32'd0);
    check("rst_rdata_cleared", cpu_rdata, 32'h0);
    mem_hold = 1'b0;
    model_reset();
    issue(1'b0, 32'h0000_0200, 32'h0);
    issue(1'b0, 32'h0000_0005, 32'h0);

    // Randomized traffic over a small address pool so hits and conflicts mix.
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 3))
        0:       ix = 7'd0;
        1:       ix = 7'd5;
        2:       ix = 7'd127;
        default: ix = 7'($urandom_range(0, 127));
      endcase
      case ($urandom_range(0, 3))
        0:       tg = 25'd0;
        1:       tg = 25'd1;
        2:       tg = 25'h1FF_FFFF;
        default: tg = 25'($urandom_range(0, 3));
      endcase
      a = {tg, ix};
      issue(($urandom_range(0, 2) == 0), a, $urandom);
    end

    repeat (10) @(negedge clk);
    check("exp_q_drained",     32'(exp_q.size()), 32'd0);
    check("mem_exp_q_drained", 32'(mem_exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global guard so the run always ends on its own.
  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got %0d vectors, expected completion", n_vec);
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter LINES, default 128: number of direct-mapped one-word lines; index = cpu_addr[6:0], tag = cpu_addr[31:7].
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 cpu_req  input  1  CPU access request; sampled only in IDLE.
REQ-005 cpu_we  input  1  1 = write, 0 = read; sampled with cpu_req.
REQ-006 cpu_addr  input  32  word address.
REQ-007 cpu_wdata  input  32  write data.
REQ-008 cpu_rdata  output  32  read data; valid while cpu_ready=1.
REQ-009 cpu_ready  output  1  one-cycle completion pulse.
REQ-010 mem_req  output  1  main-memory request; held until mem_ack.
REQ-011 mem_we  output  1  main-memory write strobe; qualified by mem_req.
REQ-012 mem_addr  output  32  main-memory address (latched cpu_addr).
REQ-013 mem_wdata  output  32  main-memory write data (latched cpu_wdata).
REQ-014 mem_rdata  input  32  main-memory read data; valid with mem_ack.
REQ-015 mem_ack  input  1  main-memory completion; one cycle.
REQ-016 c_mwr  output  1  cache data-array write enable (array samples on falling edge).
REQ-017 c_moe  output  1  cache data-array output enable.
REQ-018 c_adr  output  32  cache data-array address (latched cpu_addr).
REQ-019 c_mwd  output  32  cache data-array write data.
REQ-020 c_crd  input  32  cache data-array read data, combinational from c_adr.

Function
REQ-021 Block SHALL own a valid bit vector [LINES-1:0] and a 25-bit tag store per line; the data array holds data only.
REQ-022 FSM states SHALL be IDLE, LOOKUP, MEM_RD, MEM_WR, FILL, RESP.
REQ-023 IDLE: cpu_req=1 SHALL latch cpu_addr, cpu_we, cpu_wdata and go to LOOKUP; cpu_req=0 stays IDLE.
REQ-024 LOOKUP: c_moe=1; hit = valid[idx] and tag[idx]==addr[31:7].
REQ-025 LOOKUP, read hit: capture c_crd into cpu_rdata, go to RESP (cpu_ready in third cycle after request sampled: latency 2).
REQ-026 LOOKUP, read miss: go to MEM_RD; LOOKUP, any write: go to MEM_WR (write-through, write-allocate).
REQ-027 MEM_RD/MEM_WR: mem_req=1, mem_we=1 only in MEM_WR; remain until mem_ack=1; no timeout.
REQ-028 MEM_RD with mem_ack: capture mem_rdata into cpu_rdata and c_mwd, go to FILL.
REQ-029 MEM_WR with mem_ack: load c_mwd with latched wdata, go to FILL.
REQ-030 FILL: c_mwr=1 for exactly one cycle; set valid[idx]=1 and tag[idx]=addr[31:7] at the end of the cycle; go to RESP.
REQ-031 RESP: cpu_ready=1 for one cycle, then IDLE; cpu_rdata SHALL hold its value until the next read capture.
REQ-032 cpu_req outside IDLE SHALL be ignored; no queuing.
REQ-033 mem_ack outside MEM_RD/MEM_WR SHALL be ignored.
REQ-034 mem_addr, mem_wdata, c_adr SHALL stay stable from LOOKUP through RESP.
REQ-035 A write to a valid line with a different tag SHALL overwrite data and tag (no write-back needed).
REQ-036 Index 127 and tag 0x1FFFFFF SHALL behave as any other index and tag; no wrap or overflow behaviour.

Reset
REQ-037 rst=1 SHALL force IDLE and clear all valid bits, cpu_ready, cpu_rdata, mem_req, mem_we, c_mwr, c_moe, and all address/data outputs to 0 on the next rising edge.
REQ-038 rst during MEM_RD/MEM_WR SHALL drop mem_req the next cycle; an in-flight mem_ack is discarded; no FILL occurs.
REQ-039 rst has priority over cpu_req and mem_ack in the same cycle.

Verification
REQ-040 After reset, read 0x00000005 -> mem_req with mem_addr=0x5; ack with 0xDEADBEEF -> c_mwr pulse, cpu_ready with cpu_rdata=0xDEADBEEF.
REQ-041 Repeat read 0x00000005 -> no mem_req; cpu_ready 2 cycles after request with 0xDEADBEEF.
REQ-042 Read 0x00000085 (same index, tag 1) -> miss; mem_addr=0x85; refill replaces line; a subsequent read 0x5 misses again.
REQ-043 Write 0x0000007F data 0x12345678, ack after 5 cycles -> mem_we=1 held 5 cycles; then read 0x7F hits with 0x12345678.
REQ-044 rst asserted in MEM_RD, then mem_ack -> no c_mwr, no cpu_ready; read of same address misses.
REQ-045 cpu_req held high during a miss -> exactly one access completes per cpu_ready; stray mem_ack in IDLE causes no output change.
